// File: rtl/clk_reset_sequencer.sv
// Staged, synchronously released resets for the core, ASIC and USB domains,
// with IFCLK heartbeat supervision and a saturating soft-reset request counter.

module clk_reset_sequencer #(
   parameter int unsigned HOLD_CYCLES = 64,
   parameter int unsigned STAGE_GAP   = 16,
   parameter int unsigned HB_TIMEOUT  = 1024,
   parameter int unsigned CNT_W       = 11
) (
   input  logic       Clk,
   input  logic       reset_n,
   input  logic       soft_rst_req,
   input  logic       ifclk_hb_toggle,
   output logic       rst_core_n,
   output logic       rst_asic_n,
   output logic       rst_usb_n,
   output logic       ifclk_alive,
   output logic       seq_done,
   output logic [7:0] soft_rst_cnt
);

   typedef enum logic [1:0] {
      S_HOLD     = 2'd0,
      S_GAP_ASIC = 2'd1,
      S_GAP_USB  = 2'd2,
      S_RUN      = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] HOLD_TC      = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_TC       = CNT_W'(STAGE_GAP - 1);
   localparam logic [CNT_W-1:0] HB_TC        = CNT_W'(HB_TIMEOUT - 1);
   localparam logic [7:0]       SOFT_CNT_MAX = 8'hFF;

   logic [1:0]       r_rst_sync;
   logic             w_rst_n;
   logic [2:0]       r_hb_sync;
   logic             w_hb_edge;
   logic [CNT_W-1:0] r_hb_timer;
   logic [CNT_W-1:0] w_hb_timer_nxt;
   logic             r_alive;
   logic             w_alive_nxt;
   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_timer;
   logic [CNT_W-1:0] w_timer_nxt;
   logic             r_core_n;
   logic             w_core_n_nxt;
   logic             r_asic_n;
   logic             w_asic_n_nxt;
   logic             r_usb_n;
   logic             w_usb_n_nxt;
   logic             r_done;
   logic             w_done_nxt;
   logic [7:0]       r_soft_cnt;
   logic [7:0]       w_soft_cnt_nxt;

   // Reset synchronizer: asynchronous assert, release two edges after reset_n rises.
   always_ff @(posedge Clk or negedge reset_n) begin
      if (!reset_n) begin
         r_rst_sync <= 2'b00;
      end else begin
         r_rst_sync <= {r_rst_sync[0], 1'b1};
      end
   end

   assign w_rst_n = r_rst_sync[1];

   // Heartbeat synchronizer; an edge is any change between the last two stages.
   always_ff @(posedge Clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_hb_sync <= 3'b000;
      end else begin
         r_hb_sync <= {r_hb_sync[1:0], ifclk_hb_toggle};
      end
   end

   assign w_hb_edge = r_hb_sync[2] ^ r_hb_sync[1];

   // Heartbeat watchdog: an edge always wins over a simultaneous timeout.
   always_comb begin
      w_hb_timer_nxt = r_hb_timer;
      w_alive_nxt    = r_alive;
      if (w_hb_edge) begin
         w_hb_timer_nxt = '0;
         w_alive_nxt    = 1'b1;
      end else if (r_hb_timer == HB_TC) begin
         w_alive_nxt    = 1'b0;
      end else begin
         w_hb_timer_nxt = r_hb_timer + CNT_W'(1);
      end
   end

   always_ff @(posedge Clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_hb_timer <= '0;
         r_alive    <= 1'b0;
      end else begin
         r_hb_timer <= w_hb_timer_nxt;
         r_alive    <= w_alive_nxt;
      end
   end

   // Sequencer state and registered domain resets.
   always_ff @(posedge Clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_state    <= S_HOLD;
         r_timer    <= '0;
         r_core_n   <= 1'b0;
         r_asic_n   <= 1'b0;
         r_usb_n    <= 1'b0;
         r_done     <= 1'b0;
         r_soft_cnt <= 8'd0;
      end else begin
         r_state    <= w_state_nxt;
         r_timer    <= w_timer_nxt;
         r_core_n   <= w_core_n_nxt;
         r_asic_n   <= w_asic_n_nxt;
         r_usb_n    <= w_usb_n_nxt;
         r_done     <= w_done_nxt;
         r_soft_cnt <= w_soft_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_timer_nxt    = r_timer;
      w_core_n_nxt   = r_core_n;
      w_asic_n_nxt   = r_asic_n;
      w_usb_n_nxt    = r_usb_n;
      w_done_nxt     = r_done;
      w_soft_cnt_nxt = r_soft_cnt;

      if (soft_rst_req) begin
         w_state_nxt  = S_HOLD;
         w_timer_nxt  = '0;
         w_core_n_nxt = 1'b0;
         w_asic_n_nxt = 1'b0;
         w_usb_n_nxt  = 1'b0;
         w_done_nxt   = 1'b0;
         if (r_soft_cnt != SOFT_CNT_MAX) begin
            w_soft_cnt_nxt = r_soft_cnt + 8'd1;
         end
      end else begin
         unique case (r_state)
            S_HOLD: begin
               if (r_timer == HOLD_TC) begin
                  w_core_n_nxt = 1'b1;
                  w_timer_nxt  = '0;
                  w_state_nxt  = S_GAP_ASIC;
               end else begin
                  w_timer_nxt  = r_timer + CNT_W'(1);
               end
            end
            S_GAP_ASIC: begin
               if (r_timer == GAP_TC) begin
                  w_asic_n_nxt = 1'b1;
                  w_timer_nxt  = '0;
                  w_state_nxt  = S_GAP_USB;
               end else begin
                  w_timer_nxt  = r_timer + CNT_W'(1);
               end
            end
            S_GAP_USB: begin
               // Never release into a domain whose clock is being declared lost this edge.
               if (r_timer != GAP_TC) begin
                  w_timer_nxt = r_timer + CNT_W'(1);
               end else if (r_alive && w_alive_nxt) begin
                  w_usb_n_nxt = 1'b1;
                  w_done_nxt  = 1'b1;
                  w_timer_nxt = '0;
                  w_state_nxt = S_RUN;
               end
            end
            S_RUN: begin
               if (!w_alive_nxt) begin
                  w_usb_n_nxt = 1'b0;
                  w_done_nxt  = 1'b0;
                  w_timer_nxt = '0;
                  w_state_nxt = S_GAP_USB;
               end
            end
            default: begin
               w_state_nxt = S_HOLD;
               w_timer_nxt = '0;
            end
         endcase
      end
   end

   assign rst_core_n   = r_core_n;
   assign rst_asic_n   = r_asic_n;
   assign rst_usb_n    = r_usb_n;
   assign ifclk_alive  = r_alive;
   assign seq_done     = r_done;
   assign soft_rst_cnt = r_soft_cnt;

endmodule

// File: tb/tb_clk_reset_sequencer.sv
// Self-checking bench for clk_reset_sequencer: directed scenarios plus randomized
// soft resets and heartbeat dropouts, checked against an edge-time reference model.

module tb_clk_reset_sequencer;

   localparam int unsigned HOLD = 8;
   localparam int unsigned GAP  = 4;
   localparam int unsigned HBT  = 32;

   logic       Clk;
   logic       reset_n;
   logic       soft_rst_req;
   logic       ifclk_hb_toggle;
   logic       rst_core_n;
   logic       rst_asic_n;
   logic       rst_usb_n;
   logic       ifclk_alive;
   logic       seq_done;
   logic [7:0] soft_rst_cnt;

   logic       hb_en;
   int         n_tests = 0;
   int         n_fail  = 0;

   logic [12:0] obs;
   logic [12:0] m_exp;

   clk_reset_sequencer #(
      .HOLD_CYCLES (HOLD),
      .STAGE_GAP   (GAP),
      .HB_TIMEOUT  (HBT),
      .CNT_W       (11)
   ) dut (
      .Clk             (Clk),
      .reset_n         (reset_n),
      .soft_rst_req    (soft_rst_req),
      .ifclk_hb_toggle (ifclk_hb_toggle),
      .rst_core_n      (rst_core_n),
      .rst_asic_n      (rst_asic_n),
      .rst_usb_n       (rst_usb_n),
      .ifclk_alive     (ifclk_alive),
      .seq_done        (seq_done),
      .soft_rst_cnt    (soft_rst_cnt)
   );

   assign obs = {rst_core_n, rst_asic_n, rst_usb_n, ifclk_alive, seq_done, soft_rst_cnt};

   // Posedges fall on odd ns, heartbeat toggles and stimulus on even ns: never coincident.
   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   initial begin
      ifclk_hb_toggle = 1'b0;
      forever begin
         if (hb_en === 1'b1) begin
            #(2 * $urandom_range(5, 9));
            if (hb_en === 1'b1) ifclk_hb_toggle = ~ifclk_hb_toggle;
         end else begin
            #2;
         end
      end
   end

   // Reference model in edge time: releases are fixed offsets from the last hold start,
   // IFCLK is alive while the last observed heartbeat edge is younger than HBT edges.
   int m_n = 0;
   int m_k = 0;
   int m_hold = 0;
   int m_gap = 0;
   int m_last = 0;
   int m_cnt = 0;
   bit m_has = 0;
   bit m_usb = 0;
   bit m_alive = 0;
   bit m_alive_prev = 0;
   bit m_h[$];

   always @(posedge Clk or negedge reset_n) begin
      if (!reset_n) begin
         m_k   = 0;
         m_exp = '0;
      end else begin
         m_n++;
         if (m_k < 3) m_k++;
         if (m_k <= 2) begin
            m_h.delete();
            repeat (3) m_h.push_back(1'b0);
            m_has   = 0;
            m_alive = 0;
            m_usb   = 0;
            m_cnt   = 0;
            m_hold  = m_n;
            m_gap   = m_n + HOLD + GAP;
            m_exp   = '0;
         end else begin
            m_h.push_back(ifclk_hb_toggle === 1'b1);
            if (m_h.size() > 4) void'(m_h.pop_front());
            m_alive_prev = m_alive;
            if (m_h[0] != m_h[1]) begin
               m_has  = 1;
               m_last = m_n;
            end
            m_alive = m_has && ((m_n - m_last) < int'(HBT));
            if (soft_rst_req === 1'b1) begin
               m_hold = m_n;
               m_gap  = m_n + HOLD + GAP;
               m_usb  = 0;
               if (m_cnt < 255) m_cnt++;
            end else if (m_usb && !m_alive) begin
               m_usb = 0;
               m_gap = m_n;
            end else if (!m_usb && (m_n >= m_gap + GAP) && m_alive_prev && m_alive) begin
               m_usb = 1;
            end
            m_exp = {m_n >= m_hold + HOLD, m_n >= m_hold + HOLD + GAP, m_usb, m_alive, m_usb,
                     8'(m_cnt)};
         end
      end
   end

   task automatic release_reset();
      reset_n = 1'b0;
      repeat (3) @(negedge Clk);
      @(posedge Clk);
      #1 reset_n = 1'b1;
      @(negedge Clk);
   endtask

   task automatic test_reset();
      hb_en        = 1'b0;
      soft_rst_req = 1'b0;
      reset_n      = 1'b0;
      repeat (4) @(negedge Clk);
      n_tests++;
      if (obs !== 13'd0) begin
         n_fail++;
         $display("FAIL reset_values: got %b expected %b", obs, 13'd0);
      end
      n_tests++;
      if (obs !== m_exp) begin
         n_fail++;
         $display("FAIL reset_model: got %b expected %b", obs, m_exp);
      end
   endtask

   task automatic test_sequence();
      logic [11:0] lit;
      hb_en = 1'b1;
      release_reset();
      for (int e = 1; e <= 22; e++) begin
         @(negedge Clk);
         lit = {e >= 10, e >= 14, e >= 18, e >= 18, 8'd0};
         n_tests++;
         if ({rst_core_n, rst_asic_n, rst_usb_n, seq_done, soft_rst_cnt} !== lit) begin
            n_fail++;
            $display("FAIL seq_timing edge %0d: got %b expected %b", e,
                     {rst_core_n, rst_asic_n, rst_usb_n, seq_done, soft_rst_cnt}, lit);
         end
         n_tests++;
         if (obs !== m_exp) begin
            n_fail++;
            $display("FAIL seq_model edge %0d: got %b expected %b", e, obs, m_exp);
         end
      end
   endtask

   task automatic test_no_ifclk();
      reset_n = 1'b0;
      hb_en   = 1'b0;
      repeat (3) @(negedge Clk);
      ifclk_hb_toggle = 1'b0;
      release_reset();
      for (int e = 1; e <= 140; e++) begin
         @(negedge Clk);
         if (e == 100) hb_en = 1'b1;
         n_tests++;
         if (obs !== m_exp) begin
            n_fail++;
            $display("FAIL no_ifclk_model edge %0d: got %b expected %b", e, obs, m_exp);
         end
         if (e == 99) begin
            n_tests++;
            if ({rst_core_n, rst_asic_n, rst_usb_n, ifclk_alive, seq_done} !== 5'b11000) begin
               n_fail++;
               $display("FAIL no_ifclk_wait: got %b expected %b",
                        {rst_core_n, rst_asic_n, rst_usb_n, ifclk_alive, seq_done}, 5'b11000);
            end
         end
      end
      n_tests++;
      if ({rst_usb_n, ifclk_alive, seq_done} !== 3'b111) begin
         n_fail++;
         $display("FAIL no_ifclk_resume: got %b expected %b",
                  {rst_usb_n, ifclk_alive, seq_done}, 3'b111);
      end
   endtask

   task automatic test_hb_loss();
      hb_en = 1'b0;
      for (int i = 0; i < 90; i++) begin
         @(negedge Clk);
         if (i == 60) begin
            n_tests++;
            if ({rst_core_n, rst_asic_n, rst_usb_n, ifclk_alive, seq_done} !== 5'b11000) begin
               n_fail++;
               $display("FAIL hb_loss_drop: got %b expected %b",
                        {rst_core_n, rst_asic_n, rst_usb_n, ifclk_alive, seq_done}, 5'b11000);
            end
            hb_en = 1'b1;
         end
         n_tests++;
         if (obs !== m_exp) begin
            n_fail++;
            $display("FAIL hb_loss_model cyc %0d: got %b expected %b", i, obs, m_exp);
         end
      end
      n_tests++;
      if ({rst_core_n, rst_asic_n, rst_usb_n, seq_done} !== 4'b1111) begin
         n_fail++;
         $display("FAIL hb_loss_recover: got %b expected %b",
                  {rst_core_n, rst_asic_n, rst_usb_n, seq_done}, 4'b1111);
      end
   endtask

   task automatic test_hb_edge_vs_timeout();
      logic [1:0] lit;
      hb_en = 1'b0;
      repeat (3) @(negedge Clk);
      ifclk_hb_toggle = ~ifclk_hb_toggle;
      for (int e = 0; e <= 70; e++) begin
         @(negedge Clk);
         if (e == 31) ifclk_hb_toggle = ~ifclk_hb_toggle;
         n_tests++;
         if (obs !== m_exp) begin
            n_fail++;
            $display("FAIL hb_race_model edge %0d: got %b expected %b", e, obs, m_exp);
         end
         if (e == 34 || e == 65 || e == 66) begin
            lit = (e == 66) ? 2'b00 : 2'b11;
            n_tests++;
            if ({ifclk_alive, rst_usb_n} !== lit) begin
               n_fail++;
               $display("FAIL hb_race_alive edge %0d: got %b expected %b", e,
                        {ifclk_alive, rst_usb_n}, lit);
            end
         end
      end
      hb_en = 1'b1;
      repeat (30) begin
         @(negedge Clk);
         n_tests++;
         if (obs !== m_exp) begin
            n_fail++;
            $display("FAIL hb_race_recover: got %b expected %b", obs, m_exp);
         end
      end
   endtask

   task automatic test_soft_reset();
      logic [10:0] lit;
      @(negedge Clk);
      soft_rst_req = 1'b1;
      @(negedge Clk);
      soft_rst_req = 1'b0;
      n_tests++;
      if ({rst_core_n, rst_asic_n, rst_usb_n, seq_done, soft_rst_cnt} !== {4'b0000, 8'd1}) begin
         n_fail++;
         $display("FAIL soft_assert: got %b expected %b",
                  {rst_core_n, rst_asic_n, rst_usb_n, seq_done, soft_rst_cnt}, {4'b0000, 8'd1});
      end
      for (int e = 1; e <= 18; e++) begin
         @(negedge Clk);
         lit = {e >= 8, e >= 12, e >= 16, 8'd1};
         n_tests++;
         if ({rst_core_n, rst_asic_n, rst_usb_n, soft_rst_cnt} !== lit) begin
            n_fail++;
            $display("FAIL soft_release edge %0d: got %b expected %b", e,
                     {rst_core_n, rst_asic_n, rst_usb_n, soft_rst_cnt}, lit);
         end
         n_tests++;
         if (obs !== m_exp) begin
            n_fail++;
            $display("FAIL soft_model edge %0d: got %b expected %b", e, obs, m_exp);
         end
      end
      @(negedge Clk);
      soft_rst_req = 1'b1;
      @(negedge Clk);
      soft_rst_req = 1'b0;
      for (int e = 1; e <= 5; e++) begin
         @(negedge Clk);
         if (e == 4) soft_rst_req = 1'b1;
         if (e == 5) soft_rst_req = 1'b0;
      end
      for (int e = 0; e <= 10; e++) begin
         if (e > 0) @(negedge Clk);
         n_tests++;
         if ({rst_core_n, soft_rst_cnt} !== {e >= 8, 8'd3}) begin
            n_fail++;
            $display("FAIL soft_restart edge %0d: got %b expected %b", e,
                     {rst_core_n, soft_rst_cnt}, {e >= 8, 8'd3});
         end
         n_tests++;
         if (obs !== m_exp) begin
            n_fail++;
            $display("FAIL soft_restart_model edge %0d: got %b expected %b", e, obs, m_exp);
         end
      end
   endtask

   task automatic test_soft_at_terminal();
      hb_en = 1'b1;
      release_reset();
      for (int e = 1; e <= 20; e++) begin
         @(negedge Clk);
         if (e == 9)  soft_rst_req = 1'b1;
         if (e == 10) soft_rst_req = 1'b0;
         n_tests++;
         if ({rst_core_n, soft_rst_cnt} !== {e >= 18, (e >= 10) ? 8'd1 : 8'd0}) begin
            n_fail++;
            $display("FAIL soft_terminal edge %0d: got %b expected %b", e,
                     {rst_core_n, soft_rst_cnt}, {e >= 18, (e >= 10) ? 8'd1 : 8'd0});
         end
         n_tests++;
         if (obs !== m_exp) begin
            n_fail++;
            $display("FAIL soft_terminal_model edge %0d: got %b expected %b", e, obs, m_exp);
         end
      end
   endtask

   task automatic test_soft_saturate();
      for (int i = 0; i < 300; i++) begin
         @(negedge Clk);
         soft_rst_req = 1'b1;
         @(negedge Clk);
         soft_rst_req = 1'b0;
         n_tests++;
         if (obs !== m_exp) begin
            n_fail++;
            $display("FAIL sat_model pulse %0d: got %b expected %b", i, obs, m_exp);
         end
      end
      n_tests++;
      if (soft_rst_cnt !== 8'd255) begin
         n_fail++;
         $display("FAIL sat_count: got %0d expected 255", soft_rst_cnt);
      end
      repeat (10) @(negedge Clk);
      n_tests++;
      if ({rst_core_n, rst_asic_n, rst_usb_n} !== 3'b100) begin
         n_fail++;
         $display("FAIL sat_gap_asic: got %b expected %b",
                  {rst_core_n, rst_asic_n, rst_usb_n}, 3'b100);
      end
      #2 reset_n = 1'b0;
      #1;
      n_tests++;
      if (obs !== 13'd0) begin
         n_fail++;
         $display("FAIL async_reset: got %b expected %b", obs, 13'd0);
      end
      n_tests++;
      if (obs !== m_exp) begin
         n_fail++;
         $display("FAIL async_reset_model: got %b expected %b", obs, m_exp);
      end
   endtask

   task automatic test_random();
      hb_en = 1'b1;
      release_reset();
      for (int i = 0; i < 3000; i++) begin
         @(negedge Clk);
         n_tests++;
         if (obs !== m_exp) begin
            n_fail++;
            $display("FAIL random_model cyc %0d: got %b expected %b", i, obs, m_exp);
         end
         soft_rst_req = ($urandom_range(0, 39) == 0);
         if ($urandom_range(0, 149) == 0) hb_en = ~hb_en;
      end
      soft_rst_req = 1'b0;
   endtask

   initial begin
      reset_n      = 1'b0;
      soft_rst_req = 1'b0;
      hb_en        = 1'b0;
      test_reset();
      test_sequence();
      test_no_ifclk();
      test_hb_loss();
      test_hb_edge_vs_timeout();
      test_soft_reset();
      test_soft_at_terminal();
      test_soft_saturate();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
